coord_ascii_formatter: RTL and testbench

COORD_ASCII_FORMATTER -- requirements
Module: coord_ascii_formatter

---
 rtl/coord_ascii_formatter.sv | 135 +++++++++++++
 tb/tb_coord_ascii_formatter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/coord_ascii_formatter.sv
// Converts a signed X/Y/Z coordinate triple into three 6-character ASCII fields (sign + 5 digits).
// One shared double-dabble converter processes the axes in turn; results are published together.
module coord_ascii_formatter #(
  parameter logic [7:0] POS_CHAR = 8'h2B
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] X_in,
  input  logic [15:0] Y_in,
  input  logic [15:0] Z_in,
  input  logic        In_valid,
  output logic        In_ready,
  output logic [47:0] x_coord,
  output logic [47:0] y_coord,
  output logic [47:0] z_coord,
  output logic        Out_valid
);

  localparam logic [47:0] ZERO_TXT = {POS_CHAR, 40'h3030303030};

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, PACK, COMMIT} state_t;

  state_t      state, next_state;
  logic [1:0]  axis;
  logic [3:0]  count;
  logic [15:0] x_lat, y_lat, z_lat;
  logic [15:0] cur, abs_val, mag;
  logic [19:0] bcd, bcd_adj;
  logic [7:0]  sign;
  logic [47:0] x_stage, y_stage, z_stage;
  logic [47:0] packed_txt;

  assign In_ready = (state == IDLE) && !Rst;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (In_valid && In_ready) next_state = LOAD;
      LOAD:    next_state = SHIFT;
      SHIFT:   if (count == 4'd15) next_state = PACK;
      PACK:    next_state = (axis == 2'd2) ? COMMIT : LOAD;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    case (axis)
      2'd0:    cur = x_lat;
      2'd1:    cur = y_lat;
      default: cur = z_lat;
    endcase
  end

  // Two's-complement negate in 16 bits maps -32768 onto unsigned 32768.
  assign abs_val = cur[15] ? (~cur + 16'd1) : cur;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign packed_txt = {sign,
                       8'h30 + {4'h0, bcd[19:16]},
                       8'h30 + {4'h0, bcd[15:12]},
                       8'h30 + {4'h0, bcd[11:8]},
                       8'h30 + {4'h0, bcd[7:4]},
                       8'h30 + {4'h0, bcd[3:0]}};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      axis      <= 2'd0;
      count     <= 4'd0;
      x_lat     <= 16'd0;
      y_lat     <= 16'd0;
      z_lat     <= 16'd0;
      mag       <= 16'd0;
      bcd       <= 20'd0;
      sign      <= POS_CHAR;
      x_stage   <= ZERO_TXT;
      y_stage   <= ZERO_TXT;
      z_stage   <= ZERO_TXT;
      x_coord   <= ZERO_TXT;
      y_coord   <= ZERO_TXT;
      z_coord   <= ZERO_TXT;
      Out_valid <= 1'b0;
    end else begin
      Out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (In_valid && In_ready) begin
            x_lat <= X_in;
            y_lat <= Y_in;
            z_lat <= Z_in;
            axis  <= 2'd0;
          end
        end
        LOAD: begin
          mag   <= abs_val;
          sign  <= cur[15] ? 8'h2D : POS_CHAR;
          bcd   <= 20'd0;
          count <= 4'd0;
        end
        SHIFT: begin
          {bcd, mag} <= {bcd_adj, mag} << 1;
          count      <= count + 4'd1;
        end
        PACK: begin
          case (axis)
            2'd0:    x_stage <= packed_txt;
            2'd1:    y_stage <= packed_txt;
            default: z_stage <= packed_txt;
          endcase
          if (axis != 2'd2) axis <= axis + 2'd1;
        end
        // Outputs change only here so the serialiser never sees a mixed triple.
        COMMIT: begin
          x_coord   <= x_stage;
          y_coord   <= y_stage;
          z_coord   <= z_stage;
          Out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coord_ascii_formatter.sv
// Directed self-checking bench for coord_ascii_formatter: reset, latency, hold/back-to-back,
// input disturbance, mid-conversion reset and a short random sweep against a decimal model.
module tb_coord_ascii_formatter;

  localparam logic [47:0] ZERO_TXT = 48'h2B3030303030;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] X_in, Y_in, Z_in;
  logic        In_valid;
  logic        In_ready;
  logic [47:0] x_coord, y_coord, z_coord;
  logic        Out_valid;

  int checks   = 0;
  int failures = 0;

  coord_ascii_formatter dut (
    .Clk(Clk), .Rst(Rst),
    .X_in(X_in), .Y_in(Y_in), .Z_in(Z_in),
    .In_valid(In_valid), .In_ready(In_ready),
    .x_coord(x_coord), .y_coord(y_coord), .z_coord(z_coord),
    .Out_valid(Out_valid)
  );

  always #5 Clk = ~Clk;

  // Decimal reference: sign char followed by five digits, leading zeros kept.
  function automatic logic [47:0] fmt(input logic [15:0] v);
    int a;
    logic [47:0] r;
    a = int'($signed(v));
    r = 48'd0;
    r[47:40] = (a < 0) ? 8'h2D : 8'h2B;
    if (a < 0) a = -a;
    for (int i = 0; i < 5; i++) begin
      r[8*i +: 8] = 8'h30 + 8'(a % 10);
      a = a / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; counts edges (starting at 'start') until Out_valid, bounded.
  task automatic waitResult(input int start, output int lat);
    logic [47:0] px, py, pz;
    bit stable;
    px = x_coord; py = y_coord; pz = z_coord;
    stable = 1'b1;
    lat = start;
    while (lat < 80) begin
      @(posedge Clk);
      lat++;
      #1;
      if (Out_valid) break;
      if (x_coord !== px || y_coord !== py || z_coord !== pz) stable = 1'b0;
    end
    checkOutput("outputs_stable", 48'(stable), 48'd1);
  endtask

  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                               input logic [47:0] ex, input logic [47:0] ey, input logic [47:0] ez);
    int lat;
    @(negedge Clk);
    checkOutput("ready_before", 48'(In_ready), 48'd1);
    X_in = x; Y_in = y; Z_in = z; In_valid = 1'b1;
    @(posedge Clk);
    #1 In_valid = 1'b0;
    waitResult(0, lat);
    checkOutput("latency", 48'(lat), 48'd55);
    checkOutput("x_coord", x_coord, ex);
    checkOutput("y_coord", y_coord, ey);
    checkOutput("z_coord", z_coord, ez);
    @(posedge Clk);
    #1 checkOutput("pulse_len", 48'(Out_valid), 48'd0);
  endtask

  initial begin
    int lat;
    bit pulsed;
    logic [15:0] rx, ry, rz;

    Rst = 1'b1; In_valid = 1'b0; X_in = '0; Y_in = '0; Z_in = '0;
    #1;
    checkOutput("rst_ready", 48'(In_ready), 48'd0);
    checkOutput("rst_valid", 48'(Out_valid), 48'd0);
    checkOutput("rst_x", x_coord, ZERO_TXT);
    checkOutput("rst_y", y_coord, ZERO_TXT);
    checkOutput("rst_z", z_coord, ZERO_TXT);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1 checkOutput("ready_after_rst", 48'(In_ready), 48'd1);

    applyStimulus(16'd1234, 16'd0, 16'hFFFF, 48'h2B3031323334, 48'h2B3030303030, 48'h2D3030303031);
    applyStimulus(16'h8000, 16'h7FFF, 16'hFFF7, 48'h2D3332373638, 48'h2B3332373637, 48'h2D3030303039);

    // In_valid held high: changed data is ignored mid-conversion, then taken back-to-back.
    @(negedge Clk);
    X_in = 16'd11; Y_in = -16'sd22; Z_in = 16'd33; In_valid = 1'b1;
    @(posedge Clk);
    #1 X_in = -16'sd4444; Y_in = 16'd5555; Z_in = -16'sd6666;
    waitResult(0, lat);
    checkOutput("hold_lat_a", 48'(lat), 48'd55);
    checkOutput("hold_x_a", x_coord, 48'h2B3030303131);
    checkOutput("hold_y_a", y_coord, 48'h2D3030303232);
    checkOutput("hold_z_a", z_coord, 48'h2B3030303333);
    checkOutput("ready_with_valid", 48'(In_ready), 48'd1);
    @(posedge Clk);
    #1 checkOutput("hold_pulse_len", 48'(Out_valid), 48'd0);
    X_in = 16'd7; Y_in = 16'd8; Z_in = 16'd9;
    waitResult(0, lat);
    In_valid = 1'b0;
    checkOutput("hold_lat_b", 48'(lat), 48'd55);
    checkOutput("hold_x_b", x_coord, 48'h2D3034343434);
    checkOutput("hold_y_b", y_coord, 48'h2B3035353535);
    checkOutput("hold_z_b", z_coord, 48'h2D3036363636);
    @(posedge Clk);
    #1;
    checkOutput("hold_pulse_len_b", 48'(Out_valid), 48'd0);
    checkOutput("no_extra_accept", 48'(In_ready), 48'd1);

    // New In_valid during SHIFT must not disturb the accepted triple.
    @(negedge Clk);
    X_in = 16'd100; Y_in = -16'sd200; Z_in = 16'd300; In_valid = 1'b1;
    @(posedge Clk);
    #1 In_valid = 1'b0;
    repeat (6) @(posedge Clk);
    #1 X_in = 16'h7777; Y_in = 16'h1111; Z_in = 16'h2222; In_valid = 1'b1;
    repeat (4) @(posedge Clk);
    #1 In_valid = 1'b0;
    waitResult(10, lat);
    checkOutput("dist_lat", 48'(lat), 48'd55);
    checkOutput("dist_x", x_coord, 48'h2B3030313030);
    checkOutput("dist_y", y_coord, 48'h2D3030323030);
    checkOutput("dist_z", z_coord, 48'h2B3030333030);
    @(posedge Clk);
    #1 checkOutput("dist_pulse_len", 48'(Out_valid), 48'd0);

    // Reset mid-conversion: results discarded, no pulse, clean restart.
    @(negedge Clk);
    X_in = 16'd321; Y_in = -16'sd654; Z_in = 16'd987; In_valid = 1'b1;
    @(posedge Clk);
    #1 In_valid = 1'b0;
    repeat (30) @(posedge Clk);
    #1 Rst = 1'b1;
    #1;
    checkOutput("midrst_x", x_coord, ZERO_TXT);
    checkOutput("midrst_y", y_coord, ZERO_TXT);
    checkOutput("midrst_z", z_coord, ZERO_TXT);
    checkOutput("midrst_valid", 48'(Out_valid), 48'd0);
    checkOutput("midrst_ready", 48'(In_ready), 48'd0);
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1 checkOutput("ready_after_release", 48'(In_ready), 48'd1);
    pulsed = 1'b0;
    repeat (60) begin
      @(posedge Clk);
      #1 if (Out_valid) pulsed = 1'b1;
    end
    checkOutput("no_pulse_after_rst", 48'(pulsed), 48'd0);
    applyStimulus(16'd321, -16'sd654, 16'd987, 48'h2B3030333231, 48'h2D3030363534, 48'h2B3030393837);

    for (int i = 0; i < 8; i++) begin
      rx = 16'($urandom); ry = 16'($urandom); rz = 16'($urandom);
      applyStimulus(rx, ry, rz, fmt(rx), fmt(ry), fmt(rz));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
